// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared constants and helpers for the clock divider family
package clock_pkg;

    localparam int DIV_STOP   = 0;
    localparam int DIV_STROBE = 1;

    // High-phase length of an N-cycle divided clock: ceil(N/2).
    function automatic logic [31:0] half_up(input logic [31:0] n);
        return (n + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clock_div_bank_chan.sv
// rtl/clock_div_bank_chan.sv - one divider channel: phase counter, divisor hand-off, staged reset
module clock_div_bank_chan #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4,
    parameter int RST_STAGES  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] div_n,
    input  logic             div_load,
    input  logic             enable,
    input  logic             soft_reset,
    output logic             clk_out,
    output logic             clk_en,
    output logic             resetb_sync,
    output logic             busy
);
    import clock_pkg::*;

    logic [WIDTH-1:0]      phase;
    logic [WIDTH-1:0]      active;
    logic [WIDTH-1:0]      pending;
    logic [RST_STAGES-1:0] delay;

    logic                  running_now;
    logic                  apply;
    logic                  run;
    logic                  strobe_mode;
    logic                  high;
    logic [WIDTH-1:0]      eff_n;
    logic [WIDTH-1:0]      next_phase;
    logic [WIDTH:0]        half_n;
    logic [WIDTH:0]        phase_inc;

    always_comb begin
        running_now = enable && (active != WIDTH'(DIV_STOP));
        // Pending divisor takes over at a period start, or at once when idle.
        apply       = busy && ((phase == '0) || !running_now);
        eff_n       = apply ? pending : active;
        run         = enable && (eff_n != WIDTH'(DIV_STOP));
        strobe_mode = (eff_n == WIDTH'(DIV_STROBE));
        half_n      = (WIDTH+1)'(half_up(32'(eff_n)));
        phase_inc   = {1'b0, phase} + (WIDTH+1)'(1);
        next_phase  = (phase_inc >= {1'b0, eff_n}) ? '0 : phase_inc[WIDTH-1:0];
        high        = strobe_mode || ({1'b0, phase} < half_n);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase   <= '0;
            active  <= WIDTH'(DEFAULT_DIV);
            pending <= '0;
            busy    <= 1'b0;
            clk_out <= 1'b0;
            clk_en  <= 1'b0;
            delay   <= '1;
        end else begin
            if (apply) begin
                active <= pending;
            end

            // A fresh load wins over the clear from an apply on the same edge.
            if (div_load) begin
                pending <= div_n;
                busy    <= 1'b1;
            end else if (apply) begin
                busy    <= 1'b0;
            end

            if (run) begin
                phase   <= next_phase;
                clk_out <= high;
                clk_en  <= (phase == '0);
            end else begin
                phase   <= '0;
                clk_out <= 1'b0;
                clk_en  <= 1'b0;
            end

            if (soft_reset) begin
                delay <= '1;
            end else if (run && (phase == '0)) begin
                delay <= delay >> 1;
            end
        end
    end

    assign resetb_sync = ~(delay[0] | soft_reset);

endmodule

// File: rtl/clock_div_bank.sv
// rtl/clock_div_bank.sv - bank of independent programmable clock dividers with staged resets
module clock_div_bank #(
    parameter int NCH         = 2,
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4,
    parameter int RST_STAGES  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH*WIDTH-1:0] div_n,
    input  logic [NCH-1:0]       div_load,
    input  logic [NCH-1:0]       enable,
    input  logic [NCH-1:0]       soft_reset,
    output logic [NCH-1:0]       clk_out,
    output logic [NCH-1:0]       clk_en,
    output logic [NCH-1:0]       resetb_sync,
    output logic [NCH-1:0]       busy
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        clock_div_bank_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV),
            .RST_STAGES  (RST_STAGES)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .div_n       (div_n[i*WIDTH +: WIDTH]),
            .div_load    (div_load[i]),
            .enable      (enable[i]),
            .soft_reset  (soft_reset[i]),
            .clk_out     (clk_out[i]),
            .clk_en      (clk_en[i]),
            .resetb_sync (resetb_sync[i]),
            .busy        (busy[i])
        );
    end

endmodule

// File: tb/tb_clock_div_bank.sv
// tb/tb_clock_div_bank.sv - directed self-checking bench for clock_div_bank
module tb_clock_div_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] div_n;
    logic [1:0]  div_load;
    logic [1:0]  enable;
    logic [1:0]  soft_reset;
    logic [1:0]  clk_out;
    logic [1:0]  clk_en;
    logic [1:0]  resetb_sync;
    logic [1:0]  busy;

    int vectors    = 0;
    int miscompares = 0;
    int edge_n     = 0;

    clock_div_bank #(
        .NCH         (2),
        .WIDTH       (8),
        .DEFAULT_DIV (4),
        .RST_STAGES  (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .div_n       (div_n),
        .div_load    (div_load),
        .enable      (enable),
        .soft_reset  (soft_reset),
        .clk_out     (clk_out),
        .clk_en      (clk_en),
        .resetb_sync (resetb_sync),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] exp_o4, exp_e4, exp_r4;
        logic [9:0]  exp_o5, exp_e5, exp_e1;
        logic [5:0]  exp_o2, exp_rs;
        int          sweep_n [0:29];
        int          waited, per, hi0, hi1, n;

        exp_o4 = 12'b001100110011;
        exp_e4 = 12'b000100010001;
        exp_r4 = 12'b111100000000;
        exp_o5 = 10'b0011100111;
        exp_e5 = 10'b0000100001;
        exp_e1 = 10'b0100010001;
        exp_o2 = 6'b010101;
        exp_rs = 6'b100000;
        sweep_n = '{2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 20,
                    31, 32, 33, 63, 64, 65, 127, 128, 200, 254, 255};

        reset      = 1'b1;
        div_n      = '0;
        div_load   = '0;
        enable     = '0;
        soft_reset = '0;
        repeat (3) tick();
        chk("reset_clk_out", 32'(clk_out), 32'(0));
        chk("reset_clk_en", 32'(clk_en), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_resetb", 32'(resetb_sync), 32'(0));

        // Default divisor 4 after release, staged reset rises at edge 8.
        reset  = 1'b0;
        enable = 2'b11;
        edge_n = -1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("n4_clk_out", 32'(clk_out), 32'({2{exp_o4[k]}}));
            chk("n4_clk_en", 32'(clk_en), 32'({2{exp_e4[k]}}));
            chk("n4_resetb", 32'(resetb_sync), 32'({2{exp_r4[k]}}));
        end

        // Load 5 at p=1; takes effect at the next period start (edge 16).
        tick();
        chk("e12_clk_en", 32'(clk_en[0]), 32'(1));
        div_n    = {8'd0, 8'd5};
        div_load = 2'b01;
        tick();
        div_load = 2'b00;
        chk("load5_busy", 32'(busy), 32'(2'b01));
        chk("load5_p1_out", 32'(clk_out[0]), 32'(1));
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("load5_wait_busy", 32'(busy[0]), 32'(1));
            chk("load5_wait_out", 32'(clk_out[0]), 32'(0));
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("n5_clk_out", 32'(clk_out[0]), 32'(exp_o5[k]));
            chk("n5_clk_en", 32'(clk_en[0]), 32'(exp_e5[k]));
            chk("n5_busy", 32'(busy[0]), 32'(0));
            chk("ch1_n4_clk_en", 32'(clk_en[1]), 32'(exp_e1[k]));
        end

        // Two loads (7 then 2) in one period: only 2 reaches the boundary.
        tick();
        chk("e26_clk_en", 32'(clk_en[0]), 32'(1));
        div_n    = {8'd0, 8'd7};
        div_load = 2'b01;
        tick();
        chk("load7_busy", 32'(busy[0]), 32'(1));
        div_n    = {8'd0, 8'd2};
        tick();
        div_load = 2'b00;
        chk("load2_busy", 32'(busy[0]), 32'(1));
        chk("load2_p2_out", 32'(clk_out[0]), 32'(1));
        tick();
        chk("load2_p3_out", 32'(clk_out[0]), 32'(0));
        tick();
        chk("load2_p4_out", 32'(clk_out[0]), 32'(0));
        chk("load2_p4_busy", 32'(busy[0]), 32'(1));
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("n2_clk_out", 32'(clk_out[0]), 32'(exp_o2[k]));
            chk("n2_clk_en", 32'(clk_en[0]), 32'(exp_o2[k]));
            chk("n2_busy", 32'(busy[0]), 32'(0));
        end

        // Soft reset for 5 edges at N=2: immediate assert, release after 3 fresh strobes.
        soft_reset = 2'b01;
        #1;
        chk("soft_immediate", 32'(resetb_sync), 32'(2'b10));
        repeat (5) begin
            tick();
            chk("soft_hold", 32'(resetb_sync), 32'(2'b10));
        end
        soft_reset = 2'b00;
        #1;
        chk("soft_fall", 32'(resetb_sync), 32'(2'b10));
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("soft_release", 32'(resetb_sync[0]), 32'(exp_rs[k]));
        end

        // Strobe mode (N=1), then stop (N=0).
        div_n    = {8'd0, 8'd1};
        div_load = 2'b01;
        tick();
        div_load = 2'b00;
        chk("load1_busy", 32'(busy[0]), 32'(1));
        chk("load1_p1_en", 32'(clk_en[0]), 32'(0));
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("n1_clk_out", 32'(clk_out[0]), 32'(1));
            chk("n1_clk_en", 32'(clk_en[0]), 32'(1));
            chk("n1_busy", 32'(busy[0]), 32'(0));
        end
        div_n    = {8'd0, 8'd0};
        div_load = 2'b01;
        tick();
        div_load = 2'b00;
        chk("load0_busy", 32'(busy[0]), 32'(1));
        chk("load0_still_strobe", 32'(clk_en[0]), 32'(1));
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("n0_clk_out", 32'(clk_out[0]), 32'(0));
            chk("n0_clk_en", 32'(clk_en[0]), 32'(0));
            chk("n0_busy", 32'(busy[0]), 32'(0));
            chk("n0_resetb_frozen_hi", 32'(resetb_sync[0]), 32'(1));
        end
        soft_reset = 2'b01;
        tick();
        soft_reset = 2'b00;
        #1;
        chk("n0_soft_low", 32'(resetb_sync[0]), 32'(0));
        repeat (4) begin
            tick();
            chk("n0_resetb_frozen_lo", 32'(resetb_sync[0]), 32'(0));
        end

        // Async reset mid-period while channel 0 has a pending load.
        while ((edge_n % 4) != 3) tick();
        div_n    = {8'd0, 8'd6};
        div_load = 2'b01;
        tick();
        div_load = 2'b00;
        chk("pre_areset_busy", 32'(busy), 32'(2'b01));
        chk("pre_areset_ch1_out", 32'(clk_out[1]), 32'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("areset_clk_out", 32'(clk_out), 32'(0));
        chk("areset_clk_en", 32'(clk_en), 32'(0));
        chk("areset_busy", 32'(busy), 32'(0));
        chk("areset_resetb", 32'(resetb_sync), 32'(0));
        tick();
        chk("areset_held_out", 32'(clk_out), 32'(0));
        reset  = 1'b0;
        edge_n = -1;

        // Divisor sweep on both channels: period N, high time ceil(N/2).
        for (int s = 0; s < 30; s++) begin
            n        = sweep_n[s];
            div_n    = {2{8'(n)}};
            div_load = 2'b11;
            tick();
            div_load = 2'b00;
            waited   = 0;
            do begin
                tick();
                waited++;
            end while (clk_en !== 2'b11 && waited < 600);
            chk("sweep_boundary", 32'(clk_en), 32'(2'b11));
            chk("sweep_busy", 32'(busy), 32'(0));
            per = 0;
            hi0 = 0;
            hi1 = 0;
            do begin
                hi0 = hi0 + int'(clk_out[0]);
                hi1 = hi1 + int'(clk_out[1]);
                per++;
                tick();
            end while (clk_en[0] !== 1'b1 && per < 600);
            chk("sweep_period", 32'(per), 32'(n));
            chk("sweep_high0", 32'(hi0), 32'((n + 1) / 2));
            chk("sweep_high1", 32'(hi1), 32'((n + 1) / 2));
        end
        chk("sweep_resetb", 32'(resetb_sync), 32'(2'b11));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
